// File: rtl/sig_monitor.sv
// rtl/sig_monitor.sv - traffic signal phase monitor: decodes light pairs, checks sequencing/dwell, flags faults.
module sig_monitor #(
  parameter int Y_MIN       = 3,
  parameter int R2G_MIN     = 2,
  parameter int CNTRY_G_MAX = 10
) (
  input  logic       clock,
  input  logic       clear_n,
  input  logic [1:0] hwy,
  input  logic [1:0] cntry,
  input  logic       ack_fault,
  output logic [2:0] phase,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       fault_pulse,
  output logic [7:0] cycle_cnt
);

  typedef enum logic [2:0] {
    PH_S0  = 3'd0,
    PH_S1  = 3'd1,
    PH_S2  = 3'd2,
    PH_S3  = 3'd3,
    PH_S4  = 3'd4,
    PH_ILL = 3'd7
  } phase_t;

  phase_t     r_phase;
  logic [7:0] r_dwell;
  logic       r_armed;
  logic       r_fault;
  logic [2:0] r_code;
  logic       r_pulse;
  logic [7:0] r_cnt;

  phase_t     w_p;
  phase_t     w_succ;
  logic       w_bad_in;
  logic       w_checks;
  logic       w_leave;
  logic       w_short;
  logic       w_overrun;
  logic [2:0] w_code;
  logic       w_cycle_done;

  always_comb begin
    w_p = PH_ILL;
    case ({hwy, cntry})
      4'b10_00: w_p = PH_S0;
      4'b01_00: w_p = PH_S1;
      4'b00_00: w_p = PH_S2;
      4'b00_10: w_p = PH_S3;
      4'b00_01: w_p = PH_S4;
      default:  w_p = PH_ILL;
    endcase
  end

  always_comb begin
    w_succ = PH_ILL;
    case (r_phase)
      PH_S0:   w_succ = PH_S1;
      PH_S1:   w_succ = PH_S2;
      PH_S2:   w_succ = PH_S3;
      PH_S3:   w_succ = PH_S4;
      PH_S4:   w_succ = PH_S0;
      default: w_succ = PH_ILL;
    endcase
  end

  // Sequencing and dwell checks only apply once armed and when resynchronised to a legal phase.
  always_comb begin
    w_bad_in     = (hwy == 2'd3) || (cntry == 2'd3);
    w_checks     = r_armed && (r_phase != PH_ILL);
    w_leave      = w_checks && (w_p != PH_ILL) && (w_p == w_succ);
    w_short      = 1'b0;
    if (w_leave) begin
      if ((r_phase == PH_S1) || (r_phase == PH_S4))
        w_short = (r_dwell < 8'(Y_MIN));
      else if (r_phase == PH_S2)
        w_short = (r_dwell < 8'(R2G_MIN));
    end
    w_overrun    = w_checks && (r_phase == PH_S3) && (w_p == PH_S3) && (r_dwell == 8'(CNTRY_G_MAX));
    w_cycle_done = (r_phase == PH_S4) && (w_p == PH_S0);

    w_code = 3'd0;
    if (w_bad_in)
      w_code = 3'd1;
    else if (w_p == PH_ILL)
      w_code = 3'd2;
    else if (w_checks && (w_p != r_phase) && (w_p != w_succ))
      w_code = 3'd3;
    else if (w_short)
      w_code = 3'd4;
    else if (w_overrun)
      w_code = 3'd5;
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_phase <= PH_S0;
      r_dwell <= 8'd0;
      r_armed <= 1'b0;
      r_fault <= 1'b0;
      r_code  <= 3'd0;
      r_pulse <= 1'b0;
      r_cnt   <= 8'd0;
    end else begin
      r_armed <= 1'b1;
      r_phase <= w_p;
      if (w_p == r_phase) begin
        if (r_dwell != 8'hFF)
          r_dwell <= r_dwell + 8'd1;
      end else begin
        r_dwell <= 8'd1;
      end

      r_pulse <= (w_code != 3'd0);
      // A new fault beats a same-cycle acknowledge; otherwise the first code is held.
      if (w_code != 3'd0) begin
        if (!r_fault || ack_fault) begin
          r_fault <= 1'b1;
          r_code  <= w_code;
        end
      end else if (ack_fault) begin
        r_fault <= 1'b0;
        r_code  <= 3'd0;
      end

      if (w_cycle_done && (r_cnt != 8'hFF))
        r_cnt <= r_cnt + 8'd1;
    end
  end

  assign phase       = r_phase;
  assign fault       = r_fault;
  assign fault_code  = r_code;
  assign fault_pulse = r_pulse;
  assign cycle_cnt   = r_cnt;

endmodule
